cdb_complete_arbiter: RTL and testbench
=======================================

# cdb_complete_arbiter

Complete-stage arbiter that shares the `N` CDB slots among all functional-unit result ports each cycle. It produces `complete_gnt_bus` for the execute stage, using fixed priority by FU index with age-based anti-starvation promotion. It also drops requests from FUs whose instruction is squashed by a same-cycle branch misprediction. It sits between the FU output registers (mult/ldst/alu/branch) and the CDB mux in execute.

## Interface
- `N`, default `` `N ``: CDB slots per cycle.
- `NUM_FU`, default `` `NUM_FU_TOTAL ``: requesters; index order is mult, ldst, alu, branch (lower index = higher base priority).
- `STARVE_LIMIT`, default 4: waiting cycles before a requester is promoted; must be ≥1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `fu_req`  in  `NUM_FU`  FU holds a completed result for the CDB.
- `fu_b_mask`  in  `NUM_FU` x `B_MASK`  branch mask of each requesting instruction.
- `b_mm_resolve`  in  `B_MASK_MASK`  one-hot branch resolving this cycle.
- `b_mm_mispred`  in  1  the resolving branch mispredicted.
- `complete_gnt_bus`  out  `N` x `NUM_FU`  per-slot one-hot grant; all-zero means the slot is idle.
- `fu_gnt`  out  `NUM_FU`  OR of `complete_gnt_bus` over slots; this drives `mult_cdb_en`/`ldst_cdb_en`.
- `fu_squash`  out  `NUM_FU`  the request is killed by the mispredict this cycle.
- `cdb_slot_valid`  out  `N`  slot k carries a grant.
- `starve_active`  out  1  at least one requester is at `STARVE_LIMIT`.

## Operation
- Squash: `fu_squash[i] = fu_req[i] & b_mm_mispred & |(fu_b_mask[i] & b_mm_resolve)`.
  - A correct resolve (`b_mm_mispred`=0) never squashes.
- Effective request: `eff_req = fu_req & ~fu_squash`.
- Starving set: `starve[i] = eff_req[i] & (age[i] == STARVE_LIMIT)`.
- Selection order:
  - First all starving requesters, ascending index.
  - Then the remaining effective requesters, ascending index.
  - The first `N` in this order are granted.
  - Slot 0 gets the first selection, slot 1 the second, and so on. Slots are filled contiguously from 0.
- Each FU is granted at most one slot per cycle.
- Age counter per FU, width `$clog2(STARVE_LIMIT+1)`, updated at the clock edge:
  - Saturating +1 when `eff_req` is set and the FU is not granted.
  - Cleared to 0 otherwise: granted, squashed, or not requesting.
- A multi-cycle FU keeps `fu_req` high until `fu_gnt` is seen. The arbiter does not latch requests.
- `starve_active = |starve`.

## Timing
- Grant outputs are combinational from the same-cycle `fu_req`, `fu_b_mask`, `b_mm_*` and the registered ages. Zero-cycle latency.
- Ages update on the rising edge. A promotion takes effect in the cycle after the counter reaches `STARVE_LIMIT`.
- Reset (`reset`=0), asynchronous:
  - All ages clear to 0 immediately.
  - All outputs are forced to 0 while reset is held, regardless of `fu_req`.
  - On release, base priority resumes with all ages 0.
- Boundary conditions:
  - More than `N` starving requesters: the lowest-index starving requesters take every slot. The rest stay saturated.
  - `popcount(eff_req) ≤ N`: every effective requester is granted. Unused slots are idle.
  - Squash and request in the same cycle: no grant, and the age clears.
  - `NUM_FU < N`: the upper slots are always idle.

## Structure
- `B_MASK` and `B_MASK_MASK` are already in `sys_defs.svh`.
- Add `` `CDB_STARVE_LIMIT `` and the FU index ordering constants (`FU_IDX_MULT_BASE`, `FU_IDX_LDST_BASE`, etc.) to the shared package/`sys_defs.svh`.
- One sub-module: `cdb_slot_select`. It is a combinational N-of-M priority selector taking a request vector and producing an `N` x `M` one-hot grant.
  - It is instantiated twice: once for the starving set, once for the remainder.
  - The second instance receives `N` minus the first instance's grant count.

## Test plan
Unless stated otherwise, benches use `NUM_FU`=4, `N`=2, `STARVE_LIMIT`=2.

- Base priority: `fu_req`=4'b1110 → `complete_gnt_bus[0]`=0010, `[1]`=0100; `fu_gnt`=0110; `cdb_slot_valid`=11.
- Single request: `fu_req`=4'b1000 → slot0=1000, slot1=0000, `cdb_slot_valid`=01.
- Starvation (`N`=1): FU0 and FU3 requesting continuously.
  - Cycles 0 and 1 grant FU0; FU3 age goes to 1, then 2.
  - Cycle 2 grants FU3 with `starve_active`=1.
  - Cycle 3 grants FU0 again.
- Squash: `fu_req`=0111, `fu_b_mask[1]`=0100, `b_mm_resolve`=0100, `b_mm_mispred`=1 → grants FU0 and FU2, `fu_squash`=0010, FU1 age 0.
  - The same stimulus with `b_mm_mispred`=0 → grants FU0 and FU1.
- Reset mid-operation: FU3 age at 1, then `reset`=0 mid-cycle → all outputs 0 immediately, ages 0.
  - After release with the cycle-3 stimulus, FU3 needs 2 more losing cycles before promotion.
- Overflow of starvers: three FUs at age 2 requesting, `N`=2 → the two lowest-index starvers are granted. The third remains at age 2 and is granted next cycle.

Source files
------------

// File: rtl/cdb_complete_arbiter_pkg.sv
// Shared constants for the complete-stage CDB arbiter: slot count, FU
// index ordering, branch-mask widths and the default starvation limit.
package cdb_complete_arbiter_pkg;

  localparam int CDB_N            = 2;
  localparam int NUM_FU_TOTAL     = 4;
  localparam int B_MASK           = 4;  // branch-mask width carried by each instruction
  localparam int B_MASK_MASK      = B_MASK;
  localparam int CDB_STARVE_LIMIT = 4;

  // Lower index = higher base priority on the CDB.
  localparam int FU_IDX_MULT_BASE   = 0;
  localparam int FU_IDX_LDST_BASE   = 1;
  localparam int FU_IDX_ALU_BASE    = 2;
  localparam int FU_IDX_BRANCH_BASE = 3;

  typedef enum logic [1:0] {
    FU_MULT   = 2'(FU_IDX_MULT_BASE),
    FU_LDST   = 2'(FU_IDX_LDST_BASE),
    FU_ALU    = 2'(FU_IDX_ALU_BASE),
    FU_BRANCH = 2'(FU_IDX_BRANCH_BASE)
  } fu_kind_e;

  // Width of a saturating age counter that must be able to hold `limit`.
  function automatic int age_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cdb_complete_arbiter_if.sv
// FU-result / CDB-grant bundle between the FU output registers (master)
// and the complete-stage arbiter (slave).
interface cdb_complete_arbiter_if #(
  parameter int N      = cdb_complete_arbiter_pkg::CDB_N,
  parameter int NUM_FU = cdb_complete_arbiter_pkg::NUM_FU_TOTAL
) ();
  import cdb_complete_arbiter_pkg::*;

  logic [NUM_FU-1:0]             fu_req;
  logic [NUM_FU-1:0][B_MASK-1:0] fu_b_mask;
  logic [B_MASK_MASK-1:0]        b_mm_resolve;
  logic                          b_mm_mispred;

  logic [N-1:0][NUM_FU-1:0]      complete_gnt_bus;
  logic [NUM_FU-1:0]             fu_gnt;
  logic [NUM_FU-1:0]             fu_squash;
  logic [N-1:0]                  cdb_slot_valid;
  logic                          starve_active;

  modport master (
    output fu_req, fu_b_mask, b_mm_resolve, b_mm_mispred,
    input  complete_gnt_bus, fu_gnt, fu_squash, cdb_slot_valid, starve_active
  );

  modport slave (
    input  fu_req, fu_b_mask, b_mm_resolve, b_mm_mispred,
    output complete_gnt_bus, fu_gnt, fu_squash, cdb_slot_valid, starve_active
  );

endinterface

// File: rtl/cdb_complete_arbiter_slot.sv
// Combinational N-of-M priority selector. Grants the lowest-index
// requesters into the top `avail` slots of an N-slot window, so that a
// second instance fed with "N minus earlier grants" continues filling
// exactly where the first left off and the two grant matrices can be ORed.
module cdb_slot_select #(
  parameter  int N  = 2,
  parameter  int M  = 4,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [M-1:0]        req,
  input  logic [CW-1:0]       avail,
  output logic [N-1:0][M-1:0] gnt,
  output logic [CW-1:0]       cnt
);

  // Request i with rank r (number of lower-index requests) lands in slot
  // (N - avail) + r, if that slot exists.
  always_comb begin
    int run;
    int base;
    gnt  = '0;
    cnt  = '0;
    run  = 0;
    base = N - int'(avail);
    for (int i = 0; i < M; i++) begin
      if (req[i]) begin
        for (int k = 0; k < N; k++)
          if (k == base + run) gnt[k][i] = 1'b1;
        run++;
      end
    end
    for (int k = 0; k < N; k++) cnt = cnt + CW'(|gnt[k]);
  end

endmodule

// File: rtl/cdb_complete_arbiter.sv
// Complete-stage CDB arbiter: shares N CDB slots among FU result ports
// using fixed priority by FU index, with starving requesters promoted
// ahead of everyone else and mispredict-squashed requests dropped.
module cdb_complete_arbiter
  import cdb_complete_arbiter_pkg::*;
#(
  parameter int N            = CDB_N,
  parameter int NUM_FU       = NUM_FU_TOTAL,
  parameter int STARVE_LIMIT = CDB_STARVE_LIMIT
) (
  input  logic                  clock,
  input  logic                  reset,
  cdb_complete_arbiter_if.slave bus
);

  localparam int AW = age_width(STARVE_LIMIT);
  localparam int CW = $clog2(N + 1);

  logic [NUM_FU-1:0]         squash, eff_req, starve, rest, gnt_any;
  logic [NUM_FU-1:0][AW-1:0] age;
  logic [N-1:0][NUM_FU-1:0]  gnt_s, gnt_r, gnt;
  logic [CW-1:0]             cnt_s, cnt_r, avail_r;
  logic [N-1:0]              slot_vld;

  // Per-FU squash and starvation qualification.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign squash[i] = bus.fu_req[i] & bus.b_mm_mispred
                     & (|(bus.fu_b_mask[i] & bus.b_mm_resolve));
    assign starve[i] = eff_req[i] & (age[i] == AW'(STARVE_LIMIT));
  end

  assign eff_req = bus.fu_req & ~squash;
  assign rest    = eff_req & ~starve;

  // Starvers get first pick of the slots.
  cdb_slot_select #(.N(N), .M(NUM_FU)) u_sel_starve (
    .req   (starve),
    .avail (CW'(N)),
    .gnt   (gnt_s),
    .cnt   (cnt_s)
  );

  // Everyone else fills whatever the starvers left.
  assign avail_r = CW'(N) - cnt_s;

  cdb_slot_select #(.N(N), .M(NUM_FU)) u_sel_rest (
    .req   (rest),
    .avail (avail_r),
    .gnt   (gnt_r),
    .cnt   (cnt_r)
  );

  assign gnt = gnt_s | gnt_r;

  // Fold the slot grants per FU; slots fill contiguously so validity is a count compare.
  always_comb begin
    gnt_any  = '0;
    slot_vld = '0;
    for (int k = 0; k < N; k++) begin
      gnt_any     = gnt_any | gnt[k];
      slot_vld[k] = (int'(cnt_s) + int'(cnt_r)) > k;
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign bus.complete_gnt_bus = reset ? gnt            : '0;
  assign bus.fu_gnt           = reset ? gnt_any        : '0;
  assign bus.fu_squash        = reset ? squash         : '0;
  assign bus.cdb_slot_valid   = reset ? slot_vld       : '0;
  assign bus.starve_active    = reset ? (|starve)      : 1'b0;

  // Age: saturating count of consecutive losing cycles; any other outcome clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (eff_req[i] && !gnt_any[i]) begin
          if (age[i] != AW'(STARVE_LIMIT)) age[i] <= age[i] + AW'(1);
        end else begin
          age[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_complete_arbiter.sv
// Self-checking bench for cdb_complete_arbiter. Three instances share one
// stimulus stream: N=2/4 FUs (base function), N=1/4 FUs (starvation and
// reset), N=2/5 FUs (more starvers than slots). Idle cycles between
// scenarios clear every age counter.
module tb_cdb_complete_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [4:0]      req_v = '0;
  logic [4:0][3:0] bm_v  = '0;
  logic [3:0]      res_v = '0;
  logic            mis_v = 1'b0;

  cdb_complete_arbiter_if #(.N(2), .NUM_FU(4)) if2 ();
  cdb_complete_arbiter_if #(.N(1), .NUM_FU(4)) if1 ();
  cdb_complete_arbiter_if #(.N(2), .NUM_FU(5)) if5 ();

  assign if2.fu_req = req_v[3:0];  assign if2.fu_b_mask = bm_v[3:0];
  assign if2.b_mm_resolve = res_v; assign if2.b_mm_mispred = mis_v;
  assign if1.fu_req = req_v[3:0];  assign if1.fu_b_mask = bm_v[3:0];
  assign if1.b_mm_resolve = res_v; assign if1.b_mm_mispred = mis_v;
  assign if5.fu_req = req_v;       assign if5.fu_b_mask = bm_v;
  assign if5.b_mm_resolve = res_v; assign if5.b_mm_mispred = mis_v;

  cdb_complete_arbiter #(.N(2), .NUM_FU(4), .STARVE_LIMIT(2)) dut2 (.clock(clock), .reset(reset), .bus(if2));
  cdb_complete_arbiter #(.N(1), .NUM_FU(4), .STARVE_LIMIT(2)) dut1 (.clock(clock), .reset(reset), .bus(if1));
  cdb_complete_arbiter #(.N(2), .NUM_FU(5), .STARVE_LIMIT(2)) dut5 (.clock(clock), .reset(reset), .bus(if5));

  // Normalised view of any instance's outputs (N<=2, NUM_FU<=5).
  typedef struct {
    string           name;
    int              dut;
    logic [1:0][4:0] gnt;
    logic [4:0]      fg;
    logic [4:0]      sq;
    logic [1:0]      vld;
    logic            st;
  } obs_t;

  typedef struct {
    logic [3:0]      req;
    logic [3:0][3:0] bm;
    logic [3:0]      res;
    logic            mis;
    logic [3:0]      g0, g1, fg, sq;
    logic [1:0]      vld;
  } vec_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t sample(input int d);
    obs_t a;
    a.name = ""; a.dut = d; a.gnt = '0; a.fg = '0; a.sq = '0; a.vld = '0; a.st = 1'b0;
    case (d)
      2: begin
        a.gnt[0] = {1'b0, if2.complete_gnt_bus[0]}; a.gnt[1] = {1'b0, if2.complete_gnt_bus[1]};
        a.fg = {1'b0, if2.fu_gnt}; a.sq = {1'b0, if2.fu_squash};
        a.vld = if2.cdb_slot_valid; a.st = if2.starve_active;
      end
      1: begin
        a.gnt[0] = {1'b0, if1.complete_gnt_bus[0]};
        a.fg = {1'b0, if1.fu_gnt}; a.sq = {1'b0, if1.fu_squash};
        a.vld = {1'b0, if1.cdb_slot_valid}; a.st = if1.starve_active;
      end
      default: begin
        a.gnt = if5.complete_gnt_bus; a.fg = if5.fu_gnt; a.sq = if5.fu_squash;
        a.vld = if5.cdb_slot_valid; a.st = if5.starve_active;
      end
    endcase
    return a;
  endfunction

  task automatic push(input string nm, input int d, input logic [4:0] g0, input logic [4:0] g1,
                      input logic [4:0] fg, input logic [4:0] sq, input logic [1:0] vld, input logic st);
    obs_t e;
    e.name = nm; e.dut = d; e.gnt[0] = g0; e.gnt[1] = g1;
    e.fg = fg; e.sq = sq; e.vld = vld; e.st = st;
    sb.push_back(e);
  endtask

  task automatic check_all();
    obs_t e, a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = sample(e.dut);
      n_tests++;
      if (a.gnt !== e.gnt || a.fg !== e.fg || a.sq !== e.sq || a.vld !== e.vld || a.st !== e.st) begin
        n_fail++;
        $display("FAIL %s dut%0d: got slot0=%b slot1=%b fu_gnt=%b squash=%b valid=%b starve=%b, want slot0=%b slot1=%b fu_gnt=%b squash=%b valid=%b starve=%b",
                 e.name, e.dut, a.gnt[0], a.gnt[1], a.fg, a.sq, a.vld, a.st,
                 e.gnt[0], e.gnt[1], e.fg, e.sq, e.vld, e.st);
      end
    end
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0][3:0] bm, input logic [3:0] res, input logic mis);
    @(negedge clock);
    req_v = r; bm_v = bm; res_v = res; mis_v = mis;
  endtask

  task automatic idle();
    step(5'b0, '0, 4'b0, 1'b0);
  endtask

  vec_t tbl[9];

  initial begin
    //          req      bm        res      mis   slot0    slot1    fu_gnt   squash   valid
    tbl[0] = '{4'b1110, 16'h0000, 4'b0000, 1'b0, 4'b0010, 4'b0100, 4'b0110, 4'b0000, 2'b11};
    tbl[1] = '{4'b1000, 16'h0000, 4'b0000, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'b01};
    tbl[2] = '{4'b0111, 16'h0040, 4'b0100, 1'b1, 4'b0001, 4'b0100, 4'b0101, 4'b0010, 2'b11};
    tbl[3] = '{4'b0111, 16'h0040, 4'b0100, 1'b0, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 2'b11};
    tbl[4] = '{4'b0000, 16'h0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00};
    tbl[5] = '{4'b1111, 16'h0000, 4'b0000, 1'b0, 4'b0001, 4'b0010, 4'b0011, 4'b0000, 2'b11};
    tbl[6] = '{4'b0110, 16'h1111, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 2'b00};
    tbl[7] = '{4'b1010, 16'h8000, 4'b0010, 1'b1, 4'b0010, 4'b1000, 4'b1010, 4'b0000, 2'b11};
    tbl[8] = '{4'b1100, 16'h0300, 4'b0010, 1'b1, 4'b1000, 4'b0000, 4'b1000, 4'b0100, 2'b01};

    // Reset held: every output is zero whatever the requests.
    #1 req_v = 5'b11111;
    push("reset_hold", 2, 0, 0, 0, 0, 2'b00, 0);
    push("reset_hold", 1, 0, 0, 0, 0, 2'b00, 0);
    push("reset_hold", 5, 0, 0, 0, 0, 2'b00, 0);
    #1 check_all();
    @(negedge clock); reset = 1'b1;

    // Single-cycle vectors with all ages at zero.
    for (int v = 0; v < 9; v++) begin
      idle();
      step({1'b0, tbl[v].req}, {4'b0, tbl[v].bm}, tbl[v].res, tbl[v].mis);
      push($sformatf("vec%0d", v), 2, {1'b0, tbl[v].g0}, {1'b0, tbl[v].g1},
           {1'b0, tbl[v].fg}, {1'b0, tbl[v].sq}, tbl[v].vld, 1'b0);
      #1 check_all();
    end

    // Starvation, N=1: FU0 and FU3 both requesting every cycle.
    idle();
    step(5'b01001, '0, 4'b0, 1'b0); push("starve_c0", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("starve_c1", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("starve_c2", 1, 5'b01000, 0, 5'b01000, 0, 2'b01, 1); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("starve_c3", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();

    // Reset mid-operation with FU3 at age 1.
    idle();
    step(5'b01001, '0, 4'b0, 1'b0); push("rst_pre0", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("rst_pre1", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    #2 reset = 1'b0;
    push("rst_mid", 1, 0, 0, 0, 0, 2'b00, 0);
    push("rst_mid", 2, 0, 0, 0, 0, 2'b00, 0);
    push("rst_mid", 5, 0, 0, 0, 0, 2'b00, 0);
    #1 check_all();
    @(negedge clock); reset = 1'b1;
    push("rst_post0", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("rst_post1", 1, 5'b00001, 0, 5'b00001, 0, 2'b01, 0); #1 check_all();
    step(5'b01001, '0, 4'b0, 1'b0); push("rst_post2", 1, 5'b01000, 0, 5'b01000, 0, 2'b01, 1); #1 check_all();

    // Three starvers against two slots (5 FUs all requesting).
    idle();
    step(5'b11111, '0, 4'b0, 1'b0); push("ovf_c0", 5, 5'b00001, 5'b00010, 5'b00011, 0, 2'b11, 0); #1 check_all();
    step(5'b11111, '0, 4'b0, 1'b0); push("ovf_c1", 5, 5'b00001, 5'b00010, 5'b00011, 0, 2'b11, 0); #1 check_all();
    step(5'b11111, '0, 4'b0, 1'b0); push("ovf_c2", 5, 5'b00100, 5'b01000, 5'b01100, 0, 2'b11, 1); #1 check_all();
    step(5'b11111, '0, 4'b0, 1'b0); push("ovf_c3", 5, 5'b10000, 5'b00001, 5'b10001, 0, 2'b11, 1); #1 check_all();

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
